// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file write arbiter.
// Holds the default sizing and the fixed grant-index width.
package rf_arb_pkg;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int ZERO_REG    = 0;
    localparam int GID_W       = 3;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set request at or after ptr
// (wrapping modulo N) wins.
module rr_priority_picker
    import rf_arb_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0]     req,
    input  logic [GID_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [GID_W-1:0] idx,
    output logic             any_grant
);

    int best;
    int best_d;

    // The winner is the valid requester at the smallest circular distance from ptr.
    always_comb begin
        int d;
        best   = 0;
        best_d = N;
        d      = 0;
        for (int k = 0; k < N; k++) begin
            d = k - int'(ptr);
            if (d < 0) begin
                d = d + N;
            end
            if (req[k] && (d < best_d)) begin
                best_d = d;
                best   = k;
            end
        end
    end

    always_comb begin
        any_grant = (best_d < N);
        idx       = GID_W'(best);
        grant     = '0;
        for (int k = 0; k < N; k++) begin
            grant[k] = any_grant && (best == k);
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ
// writeback sources; the winning write appears on registered rf_* a cycle later.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int ZERO_DISCARD = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [GID_W-1:0]          grant_id
);

    logic [GID_W-1:0]   ptr;
    logic [GID_W-1:0]   pick_idx;
    logic [GID_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] pick_grant;
    logic               any_grant;
    logic               accept;
    logic               discard;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    rr_priority_picker #(
        .N (NUM_REQ)
    ) u_picker (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_grant (any_grant)
    );

    // Stall and reset both suppress the handshake, so a grant never leaks through either.
    assign accept    = any_grant & ~stall & ~rst;
    assign req_ready = accept ? pick_grant : '0;
    assign next_ptr  = (pick_idx == GID_W'(NUM_REQ - 1)) ? '0 : pick_idx + GID_W'(1);
    assign discard   = (ZERO_DISCARD != 0) && (sel_addr == ADDR_W'(ZERO_REG));

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_grant[k]) begin
                sel_addr = req_addr[k*ADDR_W +: ADDR_W];
                sel_data = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // A discarded write to the zero register still updates address, data and grant_id.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
        end else begin
            rf_we <= 1'b0;
            if (accept) begin
                rf_we    <= ~discard;
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                grant_id <= pick_idx;
                ptr      <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// randomized traffic compared against a behavioural round-robin model.
module tb_rf_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic            stall;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic [2:0]      grant_id;

    rf_write_arbiter #(
        .NUM_REQ      (N),
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .ZERO_DISCARD (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];

    // Behavioural model state
    int          m_ptr   = 0;
    logic        m_we    = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    int          m_gid   = 0;
    int          last_win = -1;
    int          wait_cnt [N];
    int          max_wait = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int off = 0; off < N; off++) begin
            if (v[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    task automatic apply_stimulus(input logic [N-1:0] v, input logic s, input logic r);
        req_valid = v;
        stall     = s;
        rst       = r;
        for (int k = 0; k < N; k++) begin
            req_addr[k*AW +: AW] = a[k];
            req_data[k*DW +: DW] = d[k];
        end
    endtask

    // One clock: check ready before the edge, advance the model, check rf_* after it.
    task automatic check_output();
        logic [N-1:0] er;
        int win;
        #1;
        win = (rst || stall) ? -1 : pick(req_valid, m_ptr);
        er = '0;
        if (win >= 0) er[win] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        if (!rst && !stall) begin
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && k != win) begin
                    wait_cnt[k]++;
                    if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
                end else begin
                    wait_cnt[k] = 0;
                end
            end
        end
        @(posedge clk);
        last_win = win;
        if (rst) begin
            m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_gid = 0;
            for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        end else begin
            m_we = 1'b0;
            if (win >= 0) begin
                m_waddr = a[win];
                m_wdata = d[win];
                m_gid   = win;
                m_we    = (a[win] != 0);
                m_ptr   = (win + 1) % N;
            end
        end
        #1;
        check("rf_we", 64'(rf_we), 64'(m_we));
        check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        check("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        check("grant_id", 64'(grant_id), 64'(m_gid));
        @(negedge clk);
    endtask

    logic [N-1:0] rv;

    initial begin
        for (int k = 0; k < N; k++) begin
            a[k] = AW'(k + 1);
            d[k] = 32'h100 + DW'(k);
            wait_cnt[k] = 0;
        end

        // Reset held two cycles with all requesters valid
        apply_stimulus(3'b111, 1'b0, 1'b1);
        check_output();
        check_output();
        check("reset_we", 64'(rf_we), 64'd0);
        check("reset_waddr", 64'(rf_waddr), 64'd0);
        check("reset_wdata", 64'(rf_wdata), 64'd0);

        // Round-robin with all valid
        apply_stimulus(3'b111, 1'b0, 1'b0);
        check_output();
        check("rr_first_gid", 64'(grant_id), 64'd0);
        check("rr_first_addr", 64'(rf_waddr), 64'd1);
        for (int c = 0; c < 5; c++) check_output();
        check("rr_last_gid", 64'(grant_id), 64'd2);
        check("rr_last_we", 64'(rf_we), 64'd1);

        // Single requester 1
        a[1] = 5'd7; d[1] = 32'hDEADBEEF;
        apply_stimulus(3'b010, 1'b0, 1'b0);
        #1 check("single_ready", 64'(req_ready), 64'b010);
        check_output();
        check("single_we", 64'(rf_we), 64'd1);
        check("single_addr", 64'(rf_waddr), 64'd7);
        check("single_data", 64'(rf_wdata), 64'hDEADBEEF);
        check("single_gid", 64'(grant_id), 64'd1);
        apply_stimulus(3'b000, 1'b0, 1'b0);
        check_output();
        check("single_drop_we", 64'(rf_we), 64'd0);

        // Move ptr to 1, then stall two cycles with all valid
        apply_stimulus(3'b001, 1'b0, 1'b0);
        check_output();
        apply_stimulus(3'b111, 1'b1, 1'b0);
        #1 check("stall_ready", 64'(req_ready), 64'd0);
        check_output();
        check_output();
        check("stall_we", 64'(rf_we), 64'd0);
        apply_stimulus(3'b111, 1'b0, 1'b0);
        #1 check("post_stall_ready", 64'(req_ready), 64'b010);
        check_output();
        check("post_stall_gid", 64'(grant_id), 64'd1);

        // Zero discard from requester 2
        a[2] = 5'd0; d[2] = 32'd5;
        apply_stimulus(3'b100, 1'b0, 1'b0);
        #1 check("zero_ready", 64'(req_ready), 64'b100);
        check_output();
        check("zero_we", 64'(rf_we), 64'd0);
        check("zero_gid", 64'(grant_id), 64'd2);
        check("zero_data", 64'(rf_wdata), 64'd5);

        // Same-address collision, then reset during a third grant
        a[0] = 5'd4; d[0] = 32'd11; a[1] = 5'd4; d[1] = 32'd22;
        apply_stimulus(3'b011, 1'b0, 1'b0);
        check_output();
        check("coll_first", 64'(rf_wdata), 64'd11);
        apply_stimulus(3'b010, 1'b0, 1'b0);
        check_output();
        check("coll_second", 64'(rf_wdata), 64'd22);
        apply_stimulus(3'b001, 1'b0, 1'b1);
        #1 check("midrst_ready", 64'(req_ready), 64'd0);
        check_output();
        check("midrst_we", 64'(rf_we), 64'd0);
        check("midrst_data", 64'(rf_wdata), 64'd0);

        // Randomized traffic obeying the hold-until-handshake rule
        rv = '0;
        max_wait = 0;
        for (int c = 0; c < 2000; c++) begin
            if (last_win >= 0) rv[last_win] = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!rv[k] && ($urandom_range(0, 1) == 1)) begin
                    rv[k] = 1'b1;
                    a[k]  = AW'($urandom_range(0, 31));
                    d[k]  = $urandom;
                end
            end
            apply_stimulus(rv, ($urandom_range(0, 4) == 0), ($urandom_range(0, 99) == 0));
            check_output();
        end
        check("fairness", 64'(max_wait < N), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
